pipe_register: RTL and testbench

- Parametrised elastic pipeline register: WIDTH-bit data through DEPTH register stages with valid/ready handshake and per-stage bubble collapse.
- Successor to the fixed 32-bit IDCT inter-stage register. Used between IDCT row/column passes and the dequantiser, where downstream stalls must not drop coefficients.
- Exposes an occupancy count for upstream flow control and debug.

---
 rtl/pipe_register.sv | 89 ++++++++
 tb/tb_pipe_register.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/pipe_register.sv
// Elastic WIDTH x DEPTH pipeline register: valid/ready handshake, bubble collapse, occupancy count.
// Optional synchronous flush port is enabled by defining PIPE_REGISTER_FLUSH_EN.
module pipe_register #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
`ifdef PIPE_REGISTER_FLUSH_EN
  input  logic             flush,
`endif
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] occupancy
);

  logic [WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [CNT_W-1:0] r_occ;

  logic [DEPTH-1:0] w_ce;
  logic [DEPTH-1:0] w_vin;
  logic [DEPTH-1:0] w_load;
  logic [DEPTH-1:0] w_vld_nxt;
  logic [WIDTH-1:0] w_din [DEPTH];
  logic [CNT_W-1:0] w_occ_nxt;

  always_comb begin
    w_ce      = '0;
    w_vin     = '0;
    w_load    = '0;
    w_vld_nxt = '0;
    w_occ_nxt = '0;
    for (int unsigned i = 0; i < DEPTH; i++) w_din[i] = '0;

    // Enables ripple from the output side: a stage may advance if the one ahead
    // advances or is itself empty, which is what collapses bubbles under a stall.
    w_ce[DEPTH-1] = out_ready | ~r_vld[DEPTH-1];
    for (int unsigned i = 1; i < DEPTH; i++)
      w_ce[DEPTH-1-i] = w_ce[DEPTH-i] | ~r_vld[DEPTH-1-i];

    w_vin[0] = in_valid;
    w_din[0] = in_data;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      w_vin[i] = r_vld[i-1];
      w_din[i] = r_data[i-1];
    end

    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_vld_nxt[i] = w_ce[i] ? w_vin[i] : r_vld[i];
      w_load[i]    = w_ce[i] & w_vin[i];
    end

`ifdef PIPE_REGISTER_FLUSH_EN
    // Flush invalidates every stage but leaves the data registers untouched.
    if (flush) begin
      w_vld_nxt = '0;
      w_load    = '0;
    end
`endif

    for (int unsigned i = 0; i < DEPTH; i++)
      w_occ_nxt = w_occ_nxt + CNT_W'(w_vld_nxt[i]);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_vld <= '0;
      r_occ <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_data[i] <= '0;
    end else begin
      r_vld <= w_vld_nxt;
      r_occ <= w_occ_nxt;
      for (int unsigned i = 0; i < DEPTH; i++)
        if (w_load[i]) r_data[i] <= w_din[i];
    end
  end

  assign in_ready  = w_ce[0];
  assign out_data  = r_data[DEPTH-1];
  assign out_valid = r_vld[DEPTH-1];
  assign occupancy = r_occ;

endmodule

// File: tb/tb_pipe_register.sv
// Self-checking bench for pipe_register (WIDTH=32, DEPTH=3): directed plan steps plus random traffic
// checked against a positional queue model of in-flight words.
module tb_pipe_register;

  localparam int W = 32;
  localparam int D = 3;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] occupancy;
`ifdef PIPE_REGISTER_FLUSH_EN
  logic          flush;
`endif

  int total = 0;
  int bad   = 0;

  // Model: each in-flight word with its stage position (0 = input side, D-1 = output side).
  logic [W-1:0] m_dat[$];
  int           m_pos[$];
  bit           m_zero = 1'b1;

  pipe_register #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef PIPE_REGISTER_FLUSH_EN
    .flush     (flush),
`endif
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic v, input logic [W-1:0] d,
                            input logic ordy, input logic f);
    logic [W-1:0] nd[$];
    int           np[$];
    int           limit;
    int           p;
    bit           acc;
    if (!r || f) begin
      m_dat.delete();
      m_pos.delete();
      if (!r) m_zero = 1'b1;
    end else begin
      acc   = v && ((m_pos.size() < D) || ordy);
      limit = D;
      foreach (m_pos[i]) begin
        if (!(i == 0 && m_pos[i] == D - 1 && ordy)) begin
          p = (m_pos[i] + 1 < limit - 1) ? m_pos[i] + 1 : limit - 1;
          limit = p;
          np.push_back(p);
          nd.push_back(m_dat[i]);
          if (p == D - 1) m_zero = 1'b0;
        end
      end
      if (acc) begin
        np.push_back(0);
        nd.push_back(d);
        if (D == 1) m_zero = 1'b0;
      end
      m_pos = np;
      m_dat = nd;
    end
  endtask

  task automatic cycle(input logic r, input logic v, input logic [W-1:0] d,
                       input logic ordy, input logic f, input bit chk);
    bit exp_vld;
    @(negedge clk);
    rst       = r;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
`ifdef PIPE_REGISTER_FLUSH_EN
    flush     = f;
`endif
    #1;
    if (chk) begin
      exp_vld = (m_pos.size() > 0) && (m_pos[0] == D - 1);
      check("in_ready", W'(in_ready), W'((m_pos.size() < D) || ordy));
      check("out_valid", W'(out_valid), W'(exp_vld));
      check("occupancy", W'(occupancy), W'(m_pos.size()));
      if (exp_vld) check("out_data", out_data, m_dat[0]);
      else if (m_zero) check("out_data_zero", out_data, '0);
    end
    @(posedge clk);
    model_step(r, v, d, ordy, f);
  endtask

  initial begin
    logic          r, v, o, f;
    logic [W-1:0]  d;

    // Reset with in_valid high
    cycle(1'b0, 1'b1, 32'h55, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'h66, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1);

    // Streaming 1..4 then drain
    for (int i = 1; i <= 4; i++) cycle(1'b1, 1'b1, W'(i), 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++)  cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b1);

    // Backpressure fill, D blocked, release with D, drain
    cycle(1'b1, 1'b1, 32'hA, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 32'hB, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 32'hC, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 32'hD, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 32'hD, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 32'hD, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b1);

    // Bubble collapse under stall, then reset mid-operation
    cycle(1'b1, 1'b1, 32'h5, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 32'h6, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 32'h7, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b1);

`ifdef PIPE_REGISTER_FLUSH_EN
    // Flush mid-operation discards held words and the word presented that cycle
    cycle(1'b1, 1'b1, 32'h8, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 32'h9, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 32'h10, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 32'h11, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b1);
`endif

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 99) != 0);
      v = ($urandom_range(0, 3) != 0);
      o = ($urandom_range(0, 2) != 0);
`ifdef PIPE_REGISTER_FLUSH_EN
      f = ($urandom_range(0, 49) == 0);
`else
      f = 1'b0;
`endif
      d = $urandom;
      cycle(r, v, d, o, f, 1'b1);
    end
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
